cpu_ibus_prefetch: RTL

//  Sequential instruction prefetcher between the CPU instruction bus (o_ibus_*) and the system bus.
//  - Fetches words at +4 ahead of the CPU into a DEPTH-entry FIFO and serves matching fetches from it.
//  - A non-sequential fetch (jump, irq) flushes the FIFO and restarts prefetch at the new address.

---
 rtl/cpu_ibus_prefetch_pkg.sv | 17 +
 rtl/cpu_ibus_prefetch_fifo.sv | 53 +++++
 rtl/cpu_ibus_prefetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_ibus_prefetch_pkg.sv
// Shared types for the instruction-bus prefetcher: FIFO entry layout,
// prefetch FSM states and the sequential fetch stride.
package CPU_Types;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } prefetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } prefetch_state_t;

    localparam logic [31:0] PF_WORD_STEP = 32'd4;

endpackage

// File: rtl/cpu_ibus_prefetch_fifo.sv
// Circular FIFO of prefetched {address, word} pairs. An extra pointer bit
// tells full from empty; flush empties it in one cycle.
module cpu_prefetch_fifo
    import CPU_Types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_push,
    input  logic [31:0]               i_push_addr,
    input  logic [31:0]               i_push_data,
    input  logic                      i_pop,
    input  logic                      i_flush,
    output logic [31:0]               o_head_addr,
    output logic [31:0]               o_head_data,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);

    prefetch_entry_t r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= '{addr: i_push_addr, data: i_push_data};
        end
    end

    assign o_head_addr = r_mem[r_rd_ptr[AW-1:0]].addr;
    assign o_head_data = r_mem[r_rd_ptr[AW-1:0]].data;
    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/cpu_ibus_prefetch.sv
// Sequential instruction prefetcher between the CPU fetch port and the system bus.
// Define CPU_PREFETCH_STATS_EN to add saturating hit/miss counters.
module cpu_ibus_prefetch
    import CPU_Types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic        i_cpu_request,
    output logic        o_cpu_ready,
    input  logic [31:0] i_cpu_address,
    output logic [31:0] o_cpu_rdata,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata
`ifdef CPU_PREFETCH_STATS_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    prefetch_state_t r_state;
    prefetch_state_t w_next_state;
    logic [31:0]     r_pf_addr;
    logic [31:0]     r_bus_addr;
    logic [31:0]     r_cpu_rdata;
    logic            r_cpu_ready;
    logic            r_stale;

    logic [31:0]     w_head_addr;
    logic [31:0]     w_head_data;
    logic            w_empty;
    logic            w_full;
    logic [CW-1:0]   w_count;

    logic w_cpu_req, w_head_match, w_hit, w_mismatch, w_bypass, w_serve;
    logic w_fifo_flush, w_bus_done, w_drop, w_push, w_issue;

    cpu_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_addr (r_pf_addr),
        .i_push_data (i_bus_rdata),
        .i_pop       (w_hit),
        .i_flush     (w_fifo_flush),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_count)
    );

    // A request in the cycle after a ready pulse is the tail of the previous
    // handshake; an explicit flush takes priority and defers the request.
    always_comb begin
        w_cpu_req    = i_cpu_request && !r_cpu_ready && !i_flush;
        w_bus_done   = (r_state == REQ) && i_bus_ready;
        w_head_match = !w_empty && (w_head_addr == i_cpu_address);
        w_hit        = w_cpu_req && w_head_match;
        w_mismatch   = w_cpu_req && !w_head_match &&
                       (!w_empty || (i_cpu_address != r_pf_addr));
        w_bypass     = w_cpu_req && w_empty && (i_cpu_address == r_pf_addr) &&
                       w_bus_done && !r_stale;
        w_serve      = w_hit || w_bypass;
        w_fifo_flush = i_flush || w_mismatch;
        w_drop       = w_bus_done && (r_stale || w_fifo_flush);
        w_push       = w_bus_done && !w_drop && !w_bypass;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // No request is issued in a flush cycle, so the latched bus address is
    // never a prefetch address that is about to be replaced.
    always_comb begin
        w_next_state  = r_state;
        w_issue       = 1'b0;
        o_bus_request = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_full && !w_fifo_flush && (int'(w_count) < DEPTH)) begin
                    w_next_state = REQ;
                    w_issue      = 1'b1;
                end
            end
            REQ: begin
                o_bus_request = 1'b1;
                if (i_bus_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pf_addr   <= '0;
            r_bus_addr  <= '0;
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_stale     <= 1'b0;
        end else begin
            r_cpu_ready <= w_serve;
            if (w_hit)         r_cpu_rdata <= w_head_data;
            else if (w_bypass) r_cpu_rdata <= i_bus_rdata;
            if (w_issue) r_bus_addr <= r_pf_addr;
            if (w_mismatch)              r_pf_addr <= i_cpu_address;
            else if (w_push || w_bypass) r_pf_addr <= r_pf_addr + PF_WORD_STEP;
            if (w_bus_done)                         r_stale <= 1'b0;
            else if (w_fifo_flush && r_state == REQ) r_stale <= 1'b1;
        end
    end

    assign o_cpu_ready   = r_cpu_ready;
    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_bus_address = r_bus_addr;

`ifdef CPU_PREFETCH_STATS_EN
    logic        r_pending_miss;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // A fetch that caused or suffered a flush is a miss when it is finally served.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pending_miss <= 1'b0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            if (w_serve) begin
                r_pending_miss <= 1'b0;
                if (r_pending_miss) begin
                    if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
                end else begin
                    if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
                end
            end else if (w_mismatch || (i_flush && i_cpu_request && !r_cpu_ready)) begin
                r_pending_miss <= 1'b1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule
